zero_extd: RTL and testbench
============================

Name: zero_extd

Overview:
- Immediate-widening unit for the pipelined CPU datapath.
- Takes an 8-bit field and produces a 16-bit operand.
- Default mode is zero-extension; sign-extension and high-byte placement are also available.
- Provides a combinational result for same-stage use and a registered copy with a valid flag for the next pipeline stage.

Parameters:
- IN_W, 8, input field width; must be >= 1.
- OUT_W, 16, output width; must be >= IN_W. Elaboration fails otherwise.

Ports:
- clk  input  1  pipeline clock; all registers update on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- dataIn  input  IN_W  field to be extended.
- mode  input  2  extension select: 00 zero, 01 sign, 10 high-place, 11 reserved (behaves as zero).
- en  input  1  stage enable; 0 = stall, registered outputs hold.
- valid_in  input  1  dataIn carries a live instruction field.
- dataOut  output  OUT_W  combinational extended result.
- dataOut_q  output  OUT_W  registered extended result.
- valid_out  output  1  registered valid flag for dataOut_q.

Behaviour:
- dataOut is purely combinational from dataIn and mode. It has zero latency and no dependence on clk, rst or en.
- mode 00 (zero-extend): dataOut[IN_W-1:0] = dataIn; dataOut[OUT_W-1:IN_W] = 0.
- mode 01 (sign-extend): low bits = dataIn; upper bits = copies of dataIn[IN_W-1].
- mode 10 (high-place): dataOut[OUT_W-1:OUT_W-IN_W] = dataIn; all lower bits = 0. When OUT_W == IN_W, output equals dataIn.
- mode 11: identical to mode 00. Reserved; no error is flagged.
- If mode or dataIn contains X/Z, the output may be X. No sanitising is required.
- Registered path, while rst is high: dataOut_q = 0 and valid_out = 0, asynchronously and immediately on assertion, independent of clk.
- Registered path, rising clk edge with rst low and en = 1: dataOut_q <= dataOut; valid_out <= valid_in. Latency is one cycle.
- Registered path, rising clk edge with rst low and en = 0: dataOut_q and valid_out hold their previous values.
- dataOut_q is captured regardless of valid_in. Consumers must qualify it with valid_out.
- Reset deasserting between edges: the registers stay 0 until the next enabled edge.
- Reset asserted mid-stream: any captured value is discarded and valid_out drops immediately.
- No internal state besides dataOut_q and valid_out.
- No handshake back-pressure; the upstream stage owns en.

Test Plan:
- mode=00, dataIn stepped 00, 21, DE, 73, 08, 47, BA, FF at 10 ns intervals -> dataOut = 0000, 0021, 00DE, 0073, 0008, 0047, 00BA, 00FF, each settling within the same step.
- mode=01, dataIn DE, 73, FF, 80 -> dataOut = FFDE, 0073, FFFF, FF80. Then mode=11, dataIn DE -> 00DE.
- mode=10, dataIn BA, 01 -> dataOut = BA00, 0100.
- rst=1 for 2 cycles, then en=1, valid_in=1, mode=00, dataIn=21 -> after the first rising edge, dataOut_q=0021 and valid_out=1. Before that edge both are 0.
- With en=1 and dataOut_q=00DE, drop en to 0 and apply dataIn=FF for 3 edges -> dataOut_q stays 00DE while dataOut shows 00FF. Raise en -> dataOut_q=00FF on the next edge.
- Assert rst asynchronously mid-cycle while dataOut_q=00BA and valid_out=1 -> both go to 0 before the next clk edge. dataOut continues to track dataIn.

Source files
------------

// File: rtl/zero_extd.sv
// Immediate-widening unit: zero/sign/high-place extension of an
// instruction field, with a combinational and a registered result.
module zero_extd #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  dataIn,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic             valid_in,
  output logic [OUT_W-1:0] dataOut,
  output logic [OUT_W-1:0] dataOut_q,
  output logic             valid_out
);

  localparam logic [1:0] ModeZero = 2'b00;
  localparam logic [1:0] ModeSign = 2'b01;
  localparam logic [1:0] ModeHigh = 2'b10;
  localparam int         HighSh   = OUT_W - IN_W;

  if (IN_W < 1) begin : gBadInW
    $error("zero_extd: IN_W must be >= 1");
  end
  if (OUT_W < IN_W) begin : gBadOutW
    $error("zero_extd: OUT_W must be >= IN_W");
  end

  logic [OUT_W-1:0] zeroExt;
  logic [OUT_W-1:0] signExt;
  logic [OUT_W-1:0] highExt;

  // Size casts widen without slicing, so OUT_W == IN_W needs no special case.
  assign zeroExt = OUT_W'(dataIn);
  assign signExt = OUT_W'($signed(dataIn));
  assign highExt = zeroExt << HighSh;

  // Pick the extension; the reserved code falls back to zero-extension.
  always_comb begin
    dataOut = zeroExt;
    case (mode)
      ModeZero: dataOut = zeroExt;
      ModeSign: dataOut = signExt;
      ModeHigh: dataOut = highExt;
      default:  dataOut = zeroExt;
    endcase
  end

  // Pipeline register: captures on enabled edges, holds on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataOut_q <= '0;
      valid_out <= 1'b0;
    end else if (en) begin
      dataOut_q <= dataOut;
      valid_out <= valid_in;
    end
  end

endmodule

// File: tb/tb_zero_extd.sv
// Self-checking bench for zero_extd: directed scenarios plus a
// randomized run against an arithmetic reference model.
module tb_zero_extd;

  logic        clk;
  logic        rst;
  logic [7:0]  dataIn;
  logic [1:0]  mode;
  logic        en;
  logic        valid_in;
  logic [15:0] dataOut;
  logic [15:0] dataOut_q;
  logic        valid_out;

  int errors = 0;
  int checks = 0;

  zero_extd #(.IN_W(8), .OUT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .dataIn(dataIn),
    .mode(mode),
    .en(en),
    .valid_in(valid_in),
    .dataOut(dataOut),
    .dataOut_q(dataOut_q),
    .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] refExt(input int d, input int m);
    int r;
    if (m == 1) r = (d >= 128) ? d + 65280 : d;
    else if (m == 2) r = d * 256;
    else r = d;
    return 16'(r);
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; valid_in = 1'b0;
    mode = 2'b00; dataIn = 8'h00;
    #1;
    checks++;
    if (dataOut_q !== 16'h0000 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: q=%h v=%b want 0000/0", dataOut_q, valid_out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; valid_in = 1'b1; mode = 2'b00; dataIn = 8'h21;
    #1;
    checks++;
    if (dataOut_q !== 16'h0000 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL pre_edge: q=%h v=%b want 0000/0", dataOut_q, valid_out);
    end
    @(posedge clk); #1;
    checks++;
    if (dataOut_q !== 16'h0021 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL first_capture: q=%h v=%b want 0021/1", dataOut_q, valid_out);
    end
  endtask

  task automatic test_zero();
    logic [7:0] vals [8] = '{8'h00, 8'h21, 8'hDE, 8'h73, 8'h08, 8'h47, 8'hBA, 8'hFF};
    mode = 2'b00;
    foreach (vals[i]) begin
      dataIn = vals[i];
      #10;
      checks++;
      if (dataOut !== {8'h00, vals[i]}) begin
        errors++;
        $display("FAIL zero_ext[%0d]: got %h want %h", i, dataOut, {8'h00, vals[i]});
      end
    end
  endtask

  task automatic test_sign();
    logic [7:0]  vals [4] = '{8'hDE, 8'h73, 8'hFF, 8'h80};
    logic [15:0] exps [4] = '{16'hFFDE, 16'h0073, 16'hFFFF, 16'hFF80};
    mode = 2'b01;
    foreach (vals[i]) begin
      dataIn = vals[i];
      #10;
      checks++;
      if (dataOut !== exps[i]) begin
        errors++;
        $display("FAIL sign_ext[%0d]: got %h want %h", i, dataOut, exps[i]);
      end
    end
    mode = 2'b11; dataIn = 8'hDE;
    #10;
    checks++;
    if (dataOut !== 16'h00DE) begin
      errors++;
      $display("FAIL reserved_mode: got %h want 00DE", dataOut);
    end
  endtask

  task automatic test_high();
    mode = 2'b10; dataIn = 8'hBA;
    #10;
    checks++;
    if (dataOut !== 16'hBA00) begin
      errors++;
      $display("FAIL high_place_BA: got %h want BA00", dataOut);
    end
    dataIn = 8'h01;
    #10;
    checks++;
    if (dataOut !== 16'h0100) begin
      errors++;
      $display("FAIL high_place_01: got %h want 0100", dataOut);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    en = 1'b1; valid_in = 1'b1; mode = 2'b00; dataIn = 8'hDE;
    @(posedge clk); #1;
    checks++;
    if (dataOut_q !== 16'h00DE) begin
      errors++;
      $display("FAIL stall_load: got %h want 00DE", dataOut_q);
    end
    @(negedge clk);
    en = 1'b0; dataIn = 8'hFF; valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dataOut_q !== 16'h00DE || valid_out !== 1'b1 || dataOut !== 16'h00FF) begin
        errors++;
        $display("FAIL stall_hold[%0d]: q=%h v=%b d=%h want 00DE/1/00FF",
                 k, dataOut_q, valid_out, dataOut);
      end
    end
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dataOut_q !== 16'h00FF || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: q=%h v=%b want 00FF/0", dataOut_q, valid_out);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    en = 1'b1; valid_in = 1'b1; mode = 2'b00; dataIn = 8'hBA;
    @(posedge clk); #1;
    checks++;
    if (dataOut_q !== 16'h00BA || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL arst_load: q=%h v=%b want 00BA/1", dataOut_q, valid_out);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (dataOut_q !== 16'h0000 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate: q=%h v=%b want 0000/0", dataOut_q, valid_out);
    end
    dataIn = 8'h47;
    #1;
    checks++;
    if (dataOut !== 16'h0047) begin
      errors++;
      $display("FAIL arst_comb: got %h want 0047", dataOut);
    end
    @(posedge clk); #1;
    checks++;
    if (dataOut_q !== 16'h0000 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL arst_held: q=%h v=%b want 0000/0", dataOut_q, valid_out);
    end
    #2 rst = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dataOut_q !== 16'h0000 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL arst_release_stall: q=%h v=%b want 0000/0", dataOut_q, valid_out);
    end
  endtask

  task automatic test_random();
    logic [15:0] expQ;
    logic        expV;
    expQ = dataOut_q === 16'h0000 ? 16'h0000 : 16'hxxxx;
    expV = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      dataIn   = 8'($urandom_range(0, 255));
      mode     = 2'($urandom_range(0, 3));
      en       = ($urandom_range(0, 3) != 0);
      valid_in = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (dataOut !== refExt(int'(dataIn), int'(mode))) begin
        errors++;
        $display("FAIL rand_comb[%0d]: d=%h m=%0d got %h want %h", n, dataIn,
                 mode, dataOut, refExt(int'(dataIn), int'(mode)));
      end
      if (en) begin
        expQ = refExt(int'(dataIn), int'(mode));
        expV = valid_in;
      end
      @(posedge clk); #1;
      checks++;
      if (dataOut_q !== expQ || valid_out !== expV) begin
        errors++;
        $display("FAIL rand_reg[%0d]: q=%h v=%b want %h/%b", n, dataOut_q,
                 valid_out, expQ, expV);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_sign();
    test_high();
    test_stall();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
